// File: rtl/muldiv_unit_if.sv
// EX-stage <-> multiply/divide unit connection: issue, operands, cancel, and result/stall signals.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             req;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rd_data;
    logic             done;

    modport master (
        output start, op, a, b, req,
        input  busy, hi, lo, rd_data, done
    );

    modport slave (
        input  start, op, a, b, req,
        output busy, hi, lo, rd_data, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and per-class latency counters.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MDU_MACC_EN.
module muldiv_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave mdu
);
    localparam int unsigned W2      = 2 * WIDTH;
    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MACC_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       op_q;
    logic             latch_en;

    function automatic logic is_mul(input logic [3:0] o);
`ifdef MDU_MACC_EN
        return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_MADD) || (o == OP_MADDU) ||
               (o == OP_MSUB) || (o == OP_MSUBU);
`else
        return (o == OP_MULT) || (o == OP_MULTU);
`endif
    endfunction

    function automatic logic is_div(input logic [3:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    assign mdu.busy    = (state_q != IDLE) |
                         (mdu.start & ~mdu.req & (is_mul(mdu.op) | is_div(mdu.op)));
    assign mdu.rd_data = (mdu.op == OP_MFHI) ? hi_q : (mdu.op == OP_MFLO) ? lo_q : '0;
    assign mdu.hi      = hi_q;
    assign mdu.lo      = lo_q;
    assign mdu.done    = done_q;

    // Products on the latched operands, full double width
    logic [W2-1:0] prod_s, prod_u, mul_res;
    assign prod_s = $unsigned($signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) *
                              $signed({{WIDTH{b_q[WIDTH-1]}}, b_q}));
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    always_comb begin
        mul_res = (op_q == OP_MULTU) ? prod_u : prod_s;
`ifdef MDU_MACC_EN
        case (op_q)
            OP_MADD:  mul_res = {hi_q, lo_q} + prod_s;
            OP_MADDU: mul_res = {hi_q, lo_q} + prod_u;
            OP_MSUB:  mul_res = {hi_q, lo_q} - prod_s;
            OP_MSUBU: mul_res = {hi_q, lo_q} - prod_u;
            default:  ;
        endcase
`endif
    end

    // Signed quotient/remainder kept in separate signed nets so the mux below stays unsigned-safe
    logic signed [WIDTH-1:0] a_s, b_s, quot_s, rem_s;
    logic [WIDTH-1:0]        quot, rem;
    logic                    div_ovf;
    assign a_s     = a_q;
    assign b_s     = b_q;
    assign quot_s  = a_s / b_s;
    assign rem_s   = a_s % b_s;
    assign div_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) & (&b_q);

    always_comb begin
        quot = a_q / b_q;
        rem  = a_q % b_q;
        if (op_q == OP_DIV) begin
            quot = div_ovf ? a_q : $unsigned(quot_s);
            rem  = div_ovf ? '0  : $unsigned(rem_s);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            if (latch_en) begin
                a_q  <= mdu.a;
                b_q  <= mdu.b;
                op_q <= mdu.op;
            end
        end
    end

    // Next-state: accept in IDLE, count down in MUL/DIV, commit when the count reaches zero
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        latch_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (mdu.start && !mdu.req) begin
                    if (is_mul(mdu.op)) begin
                        latch_en = 1'b1;
                        cnt_d    = CNT_W'(MUL_CYCLES - 1);
                        state_d  = MUL;
                    end else if (is_div(mdu.op)) begin
                        latch_en = 1'b1;
                        cnt_d    = CNT_W'(DIV_CYCLES - 1);
                        state_d  = DIV;
                    end else if (mdu.op == OP_MTHI) begin
                        hi_d = mdu.a;
                    end else if (mdu.op == OP_MTLO) begin
                        lo_d = mdu.a;
                    end
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = mul_res;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DIV: begin
                if (cnt_q == '0) begin
                    if (b_q != '0) begin
                        lo_d = quot;
                        hi_d = rem;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
